sprite_compositor: RTL
======================

// Module: sprite_compositor
// PURPOSE
//  Streaming sprite overlay for the 640x480 VGA path. Takes one background palette index per pixel
//  in raster order, overlays up to NUM_SPRITES rectangular sprites with fixed priority, and emits
//  the final 8-bit index two pipeline stages later. Sprite registers are double-buffered, so CPU/game
//  updates take effect only at frame start (no tearing). Sits between background index fetch and palette.
// PARAMETERS
//  NUM_SPRITES  4    sprite slots; slot 0 = highest priority
//  COORD_W      10   width of x/y/w/h fields and raster counters
//  IDX_W        8    palette index width
//  H_RES        640  active pixels per line
//  V_RES        480  active lines per frame
// PORTS
//  clk          in   1          pixel clock
//  resetn       in   1          asynchronous, active-low reset
//  cfg_we       in   1          write strobe into shadow registers
//  cfg_sel      in   clog2(NS)  sprite slot addressed
//  cfg_field    in   3          0=x 1=y 2=w 3=h 4=index 5=enable(bit0); 6,7 ignored
//  cfg_wdata    in   COORD_W    write data (index uses low IDX_W bits)
//  in_valid     in   1          background pixel valid
//  in_ready     out  1          compositor accepts pixel
//  in_sof       in   1          accepted pixel is (0,0) of a new frame
//  in_index     in   IDX_W      background palette index
//  out_valid    out  1          composited pixel valid
//  out_ready    in   1          downstream accepts
//  out_index    out  IDX_W      composited palette index
//  coll_valid   out  1          1-cycle pulse: coll_mask updated (COLLISION_DETECT_EN only)
//  coll_mask    out  NUM_SPRITES per-sprite overlap flags of previous frame (COLLISION_DETECT_EN only)
// BEHAVIOUR
//  - Reset: all shadow/active regs 0 (all sprites disabled), x/y counters 0, stages empty,
//    out_valid=0, out_index=0, coll_valid=0, coll_mask=0. in_ready=1 immediately after reset.
//  - Handshake: adv = !s2_valid || out_ready; in_ready = adv; both stages shift only when adv.
//    Accept = in_valid && in_ready. Data held stable on out_* while out_valid && !out_ready.
//  - Latency: exactly 2 adv cycles accept->out_valid; full throughput 1 pixel/clk with out_ready=1.
//  - Raster: accepted pixel uses (x,y); after accept x++ ; x==H_RES-1 -> x=0,y++ ; y==V_RES-1 & x
//    wraps -> y=0. Accept with in_sof=1 forces that pixel to (0,0) (resync), counters continue from there.
//  - Commit: accept with in_sof=1 copies shadow->active; that pixel already uses the new values.
//    cfg write in the same cycle as commit lands in shadow only (active gets pre-write shadow).
//  - Stage1: per slot hit = en && x>=xs && x<xs+w && y>=ys && y<ys+h, sums computed COORD_W+1
//    bits (no wrap; off-screen parts clipped, w=0 or h=0 never hits). Hit vector + in_index registered.
//  - Stage2: out_index = index of lowest-numbered hitting slot, else background in_index.
//  - Reset mid-frame: pipeline flushed, in-flight pixels dropped, counters 0; no recovery beyond sof.
// CONFIGURATION
//  COLLISION_DETECT_EN defined: stage2 ORs into frame accumulator every slot whose hit coincides with
//   any other slot's hit on the same pixel. On commit (sof accept) accumulator -> coll_mask, coll_valid
//   pulses 1 cycle, accumulator restarts with the sof pixel's contribution only.
//  Not defined: no accumulator; coll_valid and coll_mask tied 0.
// STRUCTURE
//  Package sprite_pkg: field codes (FLD_X..FLD_EN), default H_RES/V_RES, sprite_regs_t struct
//   {x,y,w,h,index,en}. Sub-module sprite_hit: one slot's bounds compare (combinational), generated
//   NUM_SPRITES times. Priority encoder and pipeline registers live in sprite_compositor.
// TESTING
//  1 Reset, no sprites, stream 640x480 ramp in_index=x[7:0] -> out_index equals input, 2-cycle latency.
//  2 Slot1 x=100 y=50 w=20 h=10 idx=4, commit -> idx 4 exactly at x 100..119, y 50..59; x=120 background.
//  3 Slots0,1 overlap at (200,200) idx 2/3 -> out 2 there; COLLISION_DETECT_EN: next sof coll_mask=0b0011.
//  4 Write slot0 x=300 mid-frame -> no change until next sof; same-cycle write+sof -> applies one frame later.
//  5 out_ready random 50% -> no pixel lost/duplicated, out_index stable while stalled, count = 307200/frame.
//  6 Slot x=630 w=40 -> hits x 630..639 only; sof at x=17 mid-line -> counters resync to (0,0).

Source files
------------

// File: rtl/sprite_pkg.sv
// Shared definitions for the sprite compositor: configuration field codes,
// default raster size and the per-slot sprite register layout.
package sprite_pkg;

  localparam int unsigned SP_COORD_W = 10;
  localparam int unsigned SP_IDX_W   = 8;
  localparam int unsigned DEF_H_RES  = 640;
  localparam int unsigned DEF_V_RES  = 480;

  typedef enum logic [2:0] {
    FLD_X   = 3'd0,
    FLD_Y   = 3'd1,
    FLD_W   = 3'd2,
    FLD_H   = 3'd3,
    FLD_IDX = 3'd4,
    FLD_EN  = 3'd5
  } cfg_field_e;

  typedef struct packed {
    logic [SP_COORD_W-1:0] x;
    logic [SP_COORD_W-1:0] y;
    logic [SP_COORD_W-1:0] w;
    logic [SP_COORD_W-1:0] h;
    logic [SP_IDX_W-1:0]   index;
    logic                  en;
  } sprite_regs_t;

endpackage

// File: rtl/sprite_hit.sv
// Rectangle membership test for one sprite slot. End coordinates are formed
// one bit wider so a sprite hanging off the right/bottom edge clips instead of wrapping.
module sprite_hit
  import sprite_pkg::*;
#(
  parameter int unsigned COORD_W = SP_COORD_W
) (
  input  logic [COORD_W-1:0] px,
  input  logic [COORD_W-1:0] py,
  input  logic [COORD_W-1:0] sx,
  input  logic [COORD_W-1:0] sy,
  input  logic [COORD_W-1:0] sw,
  input  logic [COORD_W-1:0] sh,
  input  logic               en,
  output logic               hit
);

  logic [COORD_W:0] x_end;
  logic [COORD_W:0] y_end;

  always_comb begin
    x_end = {1'b0, sx} + {1'b0, sw};
    y_end = {1'b0, sy} + {1'b0, sh};
    hit   = en
          && (px >= sx) && ({1'b0, px} < x_end)
          && (py >= sy) && ({1'b0, py} < y_end);
  end

endmodule

// File: rtl/sprite_compositor.sv
// Two-stage streaming sprite overlay with double-buffered sprite registers.
// Optional per-frame collision mask enabled by defining COLLISION_DETECT_EN.
module sprite_compositor
  import sprite_pkg::*;
#(
  parameter int unsigned NUM_SPRITES = 4,
  parameter int unsigned COORD_W     = SP_COORD_W,
  parameter int unsigned IDX_W       = SP_IDX_W,
  parameter int unsigned H_RES       = DEF_H_RES,
  parameter int unsigned V_RES       = DEF_V_RES
) (
  input  logic                           clk,
  input  logic                           resetn,
  input  logic                           cfg_we,
  input  logic [$clog2(NUM_SPRITES)-1:0] cfg_sel,
  input  logic [2:0]                     cfg_field,
  input  logic [COORD_W-1:0]             cfg_wdata,
  input  logic                           in_valid,
  output logic                           in_ready,
  input  logic                           in_sof,
  input  logic [IDX_W-1:0]               in_index,
  output logic                           out_valid,
  input  logic                           out_ready,
  output logic [IDX_W-1:0]               out_index,
  output logic                           coll_valid,
  output logic [NUM_SPRITES-1:0]         coll_mask
);

  sprite_regs_t shadow_q [NUM_SPRITES];
  sprite_regs_t shadow_d [NUM_SPRITES];
  sprite_regs_t active_q [NUM_SPRITES];
  sprite_regs_t active_d [NUM_SPRITES];
  sprite_regs_t eff      [NUM_SPRITES];

  logic [COORD_W-1:0] x_q, x_d, y_q, y_d, px, py;
  logic               adv, accept, commit;
  logic [NUM_SPRITES-1:0] hit;

  logic                   s1_valid_q, s1_valid_d;
  logic [NUM_SPRITES-1:0] s1_hit_q, s1_hit_d;
  logic [IDX_W-1:0]       s1_bg_q, s1_bg_d;
  logic [IDX_W-1:0]       s1_idx_q [NUM_SPRITES];
  logic [IDX_W-1:0]       s1_idx_d [NUM_SPRITES];
  logic                   s2_valid_q, s2_valid_d;
  logic [IDX_W-1:0]       s2_index_q, s2_index_d;
  logic [IDX_W-1:0]       win_index;

  // The sof pixel is evaluated against the freshly committed shadow set.
  always_comb begin
    adv    = !s2_valid_q || out_ready;
    accept = in_valid && adv;
    commit = accept && in_sof;
    px     = in_sof ? '0 : x_q;
    py     = in_sof ? '0 : y_q;
    for (int unsigned i = 0; i < NUM_SPRITES; i++) begin
      eff[i] = in_sof ? shadow_q[i] : active_q[i];
    end
  end

  always_comb begin
    for (int unsigned i = 0; i < NUM_SPRITES; i++) begin
      shadow_d[i] = shadow_q[i];
      active_d[i] = commit ? shadow_q[i] : active_q[i];
      if (cfg_we && (32'(cfg_sel) == i)) begin
        case (cfg_field_e'(cfg_field))
          FLD_X:   shadow_d[i].x     = cfg_wdata;
          FLD_Y:   shadow_d[i].y     = cfg_wdata;
          FLD_W:   shadow_d[i].w     = cfg_wdata;
          FLD_H:   shadow_d[i].h     = cfg_wdata;
          FLD_IDX: shadow_d[i].index = cfg_wdata[IDX_W-1:0];
          FLD_EN:  shadow_d[i].en    = cfg_wdata[0];
          default: ;
        endcase
      end
    end
  end

  always_comb begin
    x_d = x_q;
    y_d = y_q;
    if (accept) begin
      if (px == COORD_W'(H_RES - 1)) begin
        x_d = '0;
        y_d = (py == COORD_W'(V_RES - 1)) ? '0 : py + COORD_W'(1);
      end else begin
        x_d = px + COORD_W'(1);
        y_d = py;
      end
    end
  end

  for (genvar g = 0; g < NUM_SPRITES; g++) begin : g_hit
    sprite_hit #(.COORD_W(COORD_W)) u_hit (
      .px  (px),
      .py  (py),
      .sx  (eff[g].x),
      .sy  (eff[g].y),
      .sw  (eff[g].w),
      .sh  (eff[g].h),
      .en  (eff[g].en),
      .hit (hit[g])
    );
  end

  // Slot palette indices travel with the pixel so a commit cannot retint
  // the previous frame's last pixel still sitting in stage 1.
  always_comb begin
    win_index = s1_bg_q;
    for (int unsigned k = 0; k < NUM_SPRITES; k++) begin
      if (s1_hit_q[NUM_SPRITES-1-k]) win_index = s1_idx_q[NUM_SPRITES-1-k];
    end
  end

  always_comb begin
    s1_valid_d = s1_valid_q;
    s1_hit_d   = s1_hit_q;
    s1_bg_d    = s1_bg_q;
    for (int unsigned i = 0; i < NUM_SPRITES; i++) s1_idx_d[i] = s1_idx_q[i];
    s2_valid_d = s2_valid_q;
    s2_index_d = s2_index_q;
    if (adv) begin
      s1_valid_d = accept;
      s2_valid_d = s1_valid_q;
      if (accept) begin
        s1_hit_d = hit;
        s1_bg_d  = in_index;
        for (int unsigned i = 0; i < NUM_SPRITES; i++) s1_idx_d[i] = eff[i].index;
      end
      if (s1_valid_q) s2_index_d = win_index;
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      for (int unsigned i = 0; i < NUM_SPRITES; i++) begin
        shadow_q[i] <= '0;
        active_q[i] <= '0;
        s1_idx_q[i] <= '0;
      end
      x_q        <= '0;
      y_q        <= '0;
      s1_valid_q <= 1'b0;
      s1_hit_q   <= '0;
      s1_bg_q    <= '0;
      s2_valid_q <= 1'b0;
      s2_index_q <= '0;
    end else begin
      for (int unsigned i = 0; i < NUM_SPRITES; i++) begin
        shadow_q[i] <= shadow_d[i];
        active_q[i] <= active_d[i];
        s1_idx_q[i] <= s1_idx_d[i];
      end
      x_q        <= x_d;
      y_q        <= y_d;
      s1_valid_q <= s1_valid_d;
      s1_hit_q   <= s1_hit_d;
      s1_bg_q    <= s1_bg_d;
      s2_valid_q <= s2_valid_d;
      s2_index_q <= s2_index_d;
    end
  end

  assign in_ready  = adv;
  assign out_valid = s2_valid_q;
  assign out_index = s2_index_q;

`ifdef COLLISION_DETECT_EN
  logic [NUM_SPRITES-1:0] acc_q, acc_d, coll_mask_q, coll_mask_d, contrib;
  logic                   coll_valid_q, coll_valid_d, s1_sof_q, s1_sof_d, move;

  // A slot contributes only when at least one other slot hits the same pixel.
  always_comb begin
    move         = adv && s1_valid_q;
    contrib      = (|(s1_hit_q & (s1_hit_q - NUM_SPRITES'(1)))) ? s1_hit_q : '0;
    s1_sof_d     = accept ? in_sof : s1_sof_q;
    acc_d        = acc_q;
    coll_mask_d  = coll_mask_q;
    coll_valid_d = 1'b0;
    if (move) begin
      if (s1_sof_q) begin
        coll_mask_d  = acc_q;
        coll_valid_d = 1'b1;
        acc_d        = contrib;
      end else begin
        acc_d = acc_q | contrib;
      end
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      acc_q        <= '0;
      coll_mask_q  <= '0;
      coll_valid_q <= 1'b0;
      s1_sof_q     <= 1'b0;
    end else begin
      acc_q        <= acc_d;
      coll_mask_q  <= coll_mask_d;
      coll_valid_q <= coll_valid_d;
      s1_sof_q     <= s1_sof_d;
    end
  end

  assign coll_valid = coll_valid_q;
  assign coll_mask  = coll_mask_q;
`else
  assign coll_valid = 1'b0;
  assign coll_mask  = '0;
`endif

endmodule
